fetch_mem_arbiter: RTL and testbench

Arbitrates the single-port instruction memory between the pipeline fetch stage and the program loader / crypto-core read port. It sequences each memory access with a fixed latency and drives the fetch stall. It also cancels in-flight fetches on a branch redirect. It sits between the fetch stage, the loader and the memory macro.

---
 rtl/fetch_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_fetch_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares a single-port instruction memory between the
// pipeline fetch stage and the program loader, sequencing every access with
// a fixed read latency and cancelling fetches on a branch redirect.
// Optional feature macro: FETCH_ARB_STARVE_GUARD_EN (loader starvation guard).
// Default build (macro undefined): fetch has strict priority over the loader.
module fetch_mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              redirect,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_valid,
  output logic              stall_f,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_gnt,
  output logic              l_done,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned      CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);

  // Elaboration-time sanity check of the configuration
  if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_param_check
    $error("fetch_mem_arbiter: MEM_LAT and STARVE_MAX must both be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              cxl, cxl_n;
  logic              m_en_n, m_we_n;
  logic [ADDR_W-1:0] m_addr_n;
  logic [DATA_W-1:0] m_wdata_n;

  logic              fetch_done;
  logic              load_done;
  logic              arb;
  logic              l_win;
  logic              grant_l;

  // Completion cycles: a fetch or a loader read ends when the data returns,
  // a loader write ends in its single m_en cycle.
  assign fetch_done = (state == FETCH) && (cnt == CNT_LAST);
  assign load_done  = (state == LOAD) &&
                      (m_we ? (cnt == '0) : (cnt == CNT_LAST));

`ifdef FETCH_ARB_STARVE_GUARD_EN
  localparam int unsigned       SCNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_MAX);

  logic [SCNT_W-1:0] scnt, scnt_n;

  // Loader wins when fetch is quiet or has used up its consecutive grants
  assign l_win = l_req && (!f_req || (scnt == SCNT_MAX));

  // Count fetch grants taken while the loader is waiting
  always_comb begin
    scnt_n = scnt;
    if (!l_req || grant_l) begin
      scnt_n = '0;
    end else if (arb && f_req && (scnt != SCNT_MAX)) begin
      scnt_n = scnt + 1'b1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= '0;
    end else begin
      scnt <= scnt_n;
    end
  end
`else
  // Strict fetch priority: loader only gets the port when fetch is quiet
  assign l_win = l_req && !f_req;
`endif

  // Next-state, latency counter, cancel flag and memory command decode
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cxl_n     = cxl;
    m_en_n    = 1'b0;
    m_we_n    = 1'b0;
    m_addr_n  = m_addr;
    m_wdata_n = m_wdata;
    arb       = 1'b0;
    grant_l   = 1'b0;

    case (state)
      IDLE: begin
        arb = 1'b1;
      end
      FETCH: begin
        if (fetch_done) begin
          arb   = 1'b1;
          cxl_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
          if (redirect) begin
            cxl_n = 1'b1;
          end
        end
      end
      LOAD: begin
        if (load_done) begin
          arb = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        cxl_n   = 1'b0;
      end
    endcase

    if (arb) begin
      if (l_win) begin
        grant_l   = 1'b1;
        state_n   = LOAD;
        cnt_n     = '0;
        m_en_n    = 1'b1;
        m_we_n    = l_we;
        m_addr_n  = l_addr;
        m_wdata_n = l_wdata;
      end else if (f_req) begin
        state_n   = FETCH;
        cnt_n     = '0;
        m_en_n    = 1'b1;
        m_addr_n  = f_addr;
      end else begin
        state_n   = IDLE;
        cnt_n     = '0;
      end
    end
  end

  // State and registered memory command
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cxl     <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cxl     <= cxl_n;
      m_en    <= m_en_n;
      m_we    <= m_we_n;
      m_addr  <= m_addr_n;
      m_wdata <= m_wdata_n;
    end
  end

  // Requester-facing strobes; read data passes straight through from memory
  assign f_valid = !rst && fetch_done && !cxl && !redirect;
  assign f_rdata = f_valid ? m_rdata : '0;
  assign stall_f = !rst && f_req && !f_valid;
  assign l_gnt   = !rst && grant_l;
  assign l_done  = !rst && load_done;
  assign l_rdata = (l_done && !m_we) ? m_rdata : '0;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Self-checking bench for fetch_mem_arbiter: directed vector table, hand
// sequences for redirect / reset / starvation, then random traffic checked
// against a transaction-level reference model.
module tb_fetch_mem_arbiter;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;
`ifdef FETCH_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam int K_F  = 0;
  localparam int K_LR = 1;
  localparam int K_LW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, f_req, redirect, l_req, l_we;
  logic [ADDR_W-1:0] f_addr, l_addr, m_addr;
  logic [DATA_W-1:0] l_wdata, f_rdata, l_rdata, m_wdata, m_rdata;
  logic              f_valid, stall_f, l_gnt, l_done, m_en, m_we;

  fetch_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .redirect(redirect),
    .f_rdata(f_rdata), .f_valid(f_valid), .stall_f(stall_f),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_gnt(l_gnt), .l_done(l_done),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  function automatic logic [15:0] init_word(input int a);
    case (a)
      'h10:    return 16'hA5A5;
      'h30:    return 16'h3333;
      'h40:    return 16'h4444;
      default: return 16'(a * 40503) ^ 16'h5A5A;
    endcase
  endfunction

  // Memory macro model: MEM_LAT-stage read pipeline, write at the m_en edge
  logic [15:0] mem  [256];
  logic [15:0] pipe [MEM_LAT];
  assign m_rdata = pipe[MEM_LAT-1];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    for (int i = 0; i < int'(MEM_LAT); i++) pipe[i] <= '0;
    forever begin
      @(posedge clk);
      if (m_en && m_we) mem[m_addr[7:0]] <= m_wdata;
      pipe[0] <= m_en ? mem[m_addr[7:0]] : 16'hDEAD;
      for (int i = 1; i < int'(MEM_LAT); i++) pipe[i] <= pipe[i-1];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: one outstanding transaction with its start/done cycle
  logic [15:0] ref_mem [256];
  bit          busy = 1'b0;
  int          kind = K_F;
  logic [15:0] t_addr, t_data;
  int          t_start, t_done;
  bit          cxl_m = 1'b0;
  int          scnt_m = 0;
  bit          last_gnt = 1'b0;

  logic        o_fv, o_stall, o_gnt, o_ld, o_men, o_mwe;
  logic [15:0] o_frd, o_lrd, o_madr, o_mwd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_check();
    logic        e_fv, e_ld, e_gnt, completing, arb, lwin;
    logic [15:0] e_frd, e_lrd;
    o_fv = f_valid; o_frd = f_rdata; o_stall = stall_f; o_gnt = l_gnt;
    o_ld = l_done; o_lrd = l_rdata; o_men = m_en; o_mwe = m_we;
    o_madr = m_addr; o_mwd = m_wdata;
    e_gnt = 1'b0;
    if (rst) begin
      chk("rst_f_valid", f_valid, 0);
      chk("rst_stall_f", stall_f, 0);
      chk("rst_l_gnt", l_gnt, 0);
      chk("rst_l_done", l_done, 0);
      chk("rst_f_rdata", f_rdata, 0);
      chk("rst_l_rdata", l_rdata, 0);
      busy = 1'b0; scnt_m = 0; cxl_m = 1'b0;
    end else begin
      if (busy && cyc == t_start) begin
        chk("m_en", m_en, 1);
        chk("m_addr", m_addr, t_addr);
        chk("m_we", m_we, (kind == K_LW) ? 1 : 0);
        if (kind == K_LW) chk("m_wdata", m_wdata, t_data);
      end else begin
        chk("m_en", m_en, 0);
      end
      completing = busy && (cyc == t_done);
      e_fv  = completing && kind == K_F && !cxl_m && !redirect;
      e_ld  = completing && kind != K_F;
      e_frd = e_fv ? ref_mem[t_addr[7:0]] : 16'h0;
      e_lrd = (e_ld && kind == K_LR) ? ref_mem[t_addr[7:0]] : 16'h0;
      if (e_ld && kind == K_LW) ref_mem[t_addr[7:0]] = t_data;
      arb = !busy || completing;
      if (arb) begin
        lwin = l_req && (!f_req || (GUARD && scnt_m == int'(STARVE_MAX)));
        if (lwin) begin
          e_gnt = 1'b1; busy = 1'b1; kind = l_we ? K_LW : K_LR;
          t_addr = l_addr; t_data = l_wdata; t_start = cyc + 1;
          t_done = t_start + (l_we ? 0 : int'(MEM_LAT));
          cxl_m = 1'b0; scnt_m = 0;
        end else if (f_req) begin
          busy = 1'b1; kind = K_F; t_addr = f_addr; t_start = cyc + 1;
          t_done = t_start + int'(MEM_LAT); cxl_m = 1'b0;
          scnt_m = !l_req ? 0 : (scnt_m < int'(STARVE_MAX) ? scnt_m + 1 : scnt_m);
        end else begin
          busy = 1'b0;
          if (!l_req) scnt_m = 0;
        end
      end else begin
        if (kind == K_F && redirect) cxl_m = 1'b1;
        if (!l_req) scnt_m = 0;
      end
      chk("f_valid", f_valid, e_fv);
      chk("f_rdata", f_rdata, e_frd);
      chk("stall_f", stall_f, f_req && !e_fv);
      chk("l_gnt", l_gnt, e_gnt);
      chk("l_done", l_done, e_ld);
      chk("l_rdata", l_rdata, e_lrd);
    end
    last_gnt = e_gnt;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, f_req;
    logic [15:0] f_addr;
    logic        redirect, l_req, l_we;
    logic [15:0] l_addr, l_wdata;
    logic        e_fv;
    logic [15:0] e_frd;
    logic        e_stall, e_gnt, e_ld, chk_men, e_men;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic r, input logic fq, input logic [15:0] fa,
                              input logic rd, input logic lq, input logic lw,
                              input logic [15:0] la, input logic [15:0] lwd,
                              input logic efv, input logic [15:0] efrd,
                              input logic est, input logic eg, input logic eld,
                              input logic cm, input logic em);
    vec_t v;
    v.rst = r; v.f_req = fq; v.f_addr = fa; v.redirect = rd; v.l_req = lq;
    v.l_we = lw; v.l_addr = la; v.l_wdata = lwd; v.e_fv = efv; v.e_frd = efrd;
    v.e_stall = est; v.e_gnt = eg; v.e_ld = eld; v.chk_men = cm; v.e_men = em;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_fv;
    bit  got;
    bit  lpend;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; f_req = 1'b0; f_addr = '0; redirect = 1'b0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;

    //          rst fq faddr    rd lq lw laddr    lwdata   | fv frd      st g  ld cm em
    tbl[0]  = mk(1, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 0);
    tbl[3]  = mk(0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 1);
    tbl[4]  = mk(0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 0);
    tbl[5]  = mk(0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 1);
    tbl[7]  = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0020, 16'h1234, 0, 16'h0000, 0, 1, 0, 1, 0);
    tbl[11] = mk(0, 1, 16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 1, 1, 1);
    tbl[12] = mk(0, 1, 16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 1);
    tbl[13] = mk(0, 1, 16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0, 0, 1, 0);
    tbl[15] = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 0);

    @(posedge clk);
    #1;

    // Directed vectors: reset, first fetch latency, loader write then fetch
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; f_req = tbl[i].f_req; f_addr = tbl[i].f_addr;
      redirect = tbl[i].redirect; l_req = tbl[i].l_req; l_we = tbl[i].l_we;
      l_addr = tbl[i].l_addr; l_wdata = tbl[i].l_wdata;
      tick();
      chk($sformatf("vec%0d_f_valid", i), o_fv, tbl[i].e_fv);
      chk($sformatf("vec%0d_f_rdata", i), o_frd, tbl[i].e_frd);
      chk($sformatf("vec%0d_stall_f", i), o_stall, tbl[i].e_stall);
      chk($sformatf("vec%0d_l_gnt", i), o_gnt, tbl[i].e_gnt);
      chk($sformatf("vec%0d_l_done", i), o_ld, tbl[i].e_ld);
      if (tbl[i].chk_men) chk($sformatf("vec%0d_m_en", i), o_men, tbl[i].e_men);
    end

    // Redirect in cycle 2 of a fetch to 0x30; next access fetches 0x40
    n_fv = 0;
    f_req = 1'b1; f_addr = 16'h0030; redirect = 1'b0;
    tick(); n_fv += int'(o_fv);
    tick(); n_fv += int'(o_fv);
    redirect = 1'b1; f_addr = 16'h0040;
    tick(); n_fv += int'(o_fv);
    redirect = 1'b0;
    tick(); n_fv += int'(o_fv);
    chk("redir_suppressed_at_completion", o_fv, 0);
    f_req = 1'b0;
    tick(); n_fv += int'(o_fv);
    tick(); n_fv += int'(o_fv);
    chk("redir_no_early_valid", n_fv, 0);
    tick();
    chk("redir_new_valid", o_fv, 1);
    chk("redir_new_data", o_frd, ref_mem[8'h40]);
    tick();

    // Reset during cnt==1 of a loader read
    l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0060;
    tick();
    chk("rstrd_gnt", o_gnt, 1);
    l_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rstrd_m_en", o_men, 0);
    chk("rstrd_m_we", o_mwe, 0);
    chk("rstrd_m_addr", o_madr, 0);
    chk("rstrd_m_wdata", o_mwd, 0);
    chk("rstrd_f_valid", o_fv, 0);
    chk("rstrd_l_gnt", o_gnt, 0);
    chk("rstrd_l_done", o_ld, 0);
    chk("rstrd_l_rdata", o_lrd, 0);
    n_fv = int'(o_ld);
    for (int i = 0; i < 4; i++) begin tick(); n_fv += int'(o_ld); end
    chk("rstrd_no_l_done", n_fv, 0);
    l_req = 1'b1; l_addr = 16'h0060;
    tick();
    chk("rstrd_regrant", o_gnt, 1);
    l_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (o_ld) begin got = 1'b1; chk("rstrd_reread_data", o_lrd, ref_mem[8'h60]); end
    end
    chk("rstrd_reread_done", got, 1);
    tick();

    // Fetch held high while the loader waits
    f_req = 1'b1; f_addr = 16'h0011; l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0050;
    n_fv = 0; got = 1'b0;
    if (GUARD) begin
      for (int i = 0; i < 60 && !got; i++) begin
        tick(); n_fv += int'(o_fv);
        if (o_gnt) got = 1'b1;
      end
      chk("starve_gnt", got, 1);
      chk("starve_fetches_before_gnt", n_fv, STARVE_MAX);
      l_req = 1'b0; got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin tick(); got = o_ld; end
      chk("starve_l_done", got, 1);
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin tick(); got = o_fv; end
      chk("starve_fetch_resumes", got, 1);
    end else begin
      for (int i = 0; i < 40; i++) begin tick(); n_fv += int'(o_gnt); end
      chk("strict_no_gnt_while_freq", n_fv, 0);
      f_req = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin tick(); got = o_gnt; end
      chk("strict_gnt_after_fdrop", got, 1);
      l_req = 1'b0; got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        tick();
        if (o_ld) begin got = 1'b1; chk("strict_l_rdata", o_lrd, ref_mem[8'h50]); end
      end
      chk("strict_l_done", got, 1);
    end
    f_req = 1'b0; l_req = 1'b0;
    tick(); tick(); tick();

    // Random traffic against the reference model
    lpend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      f_req    = ($urandom_range(0, 9) < 7);
      f_addr   = 16'($urandom_range(0, 63));
      redirect = ($urandom_range(0, 9) == 0);
      if (lpend && last_gnt) lpend = 1'b0;
      if (!lpend && $urandom_range(0, 4) == 0) begin
        lpend   = 1'b1;
        l_we    = 1'($urandom_range(0, 1));
        l_addr  = 16'($urandom_range(0, 63));
        l_wdata = 16'($urandom);
      end
      l_req = lpend;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
